// File: rtl/ins_queue.sv
// Instruction-parcel queue: splits aligned fetch words into 16-bit parcels and
// presents up to NOUT of them per cycle, in program order, with their PC.
module ins_queue #(
    parameter int unsigned RV    = 32,
    parameter int unsigned FW    = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NOUT  = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic [RV-1:0]        flush_pc_i,
    input  logic                 fetch_valid_i,
    output logic                 fetch_ready_o,
    input  logic [FW-1:0]        fetch_data_i,
    input  logic [RV-1:0]        fetch_pc_i,
    output logic [1:0]           out_count_o,
    output logic [NOUT*16-1:0]   out_ins_o,
    output logic [RV-1:0]        out_pc_o,
    input  logic [1:0]           consume_i
);

    localparam int unsigned P  = FW / 16;
    localparam int unsigned WB = FW / 8;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OB = $clog2(WB);
    localparam int unsigned SW = OB - 1;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [RV-1:0] out_pc_q, out_pc_d;
    logic [RV-1:0] exp_pc_q, exp_pc_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          accept;
    logic          wr_en;
    logic [CW-1:0] n_wr;

    assign fetch_ready_o = (count_q <= CW'(DEPTH - P));
    assign accept        = fetch_valid_i && fetch_ready_o && !flush_i;
    assign wr_en         = accept && (fetch_pc_i == exp_pc_q);
    assign n_wr          = CW'(P) - CW'(skip_q);

    // Next-state: flush overrides; otherwise consume and matching write combine.
    always_comb begin
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q;
        out_pc_d = out_pc_q;
        exp_pc_d = exp_pc_q;
        skip_d   = skip_q;
        if (flush_i) begin
            rptr_d   = '0;
            wptr_d   = '0;
            count_d  = '0;
            out_pc_d = flush_pc_i & ~RV'(1);
            exp_pc_d = flush_pc_i & ~RV'(WB - 1);
            skip_d   = flush_pc_i[OB-1:1];
        end else begin
            rptr_d   = rptr_q + PW'(consume_i);
            out_pc_d = out_pc_q + RV'({consume_i, 1'b0});
            count_d  = count_q - CW'(consume_i);
            if (wr_en) begin
                wptr_d   = wptr_q + PW'(n_wr);
                count_d  = count_d + n_wr;
                skip_d   = '0;
                exp_pc_d = exp_pc_q + RV'(WB);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            out_pc_q <= '0;
            exp_pc_q <= '0;
            skip_q   <= '0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            out_pc_q <= out_pc_d;
            exp_pc_q <= exp_pc_d;
            skip_q   <= skip_d;
        end
    end

    // Parcels below skip belong before the redirect target and are dropped.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < int'(P); i++) begin
                if (i >= int'(skip_q)) begin
                    mem_q[PW'(int'(wptr_q) + i - int'(skip_q))] <= fetch_data_i[16*i +: 16];
                end
            end
        end
    end

    always_comb begin
        out_ins_o = '0;
        for (int k = 0; k < int'(NOUT); k++) begin
            out_ins_o[16*k +: 16] = mem_q[rptr_q + PW'(k)];
        end
    end

    assign out_count_o = (count_q >= CW'(NOUT)) ? 2'(NOUT) : 2'(count_q);
    assign out_pc_o    = out_pc_q;

endmodule

// File: tb/tb_ins_queue.sv
// Scoreboard bench for ins_queue: a parcel-queue reference model predicts each
// cycle's outputs; a negedge monitor compares them against the DUT.
module tb_ins_queue;

    localparam int unsigned RV    = 32;
    localparam int unsigned FW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NOUT  = 2;
    localparam int unsigned P     = FW / 16;
    localparam int unsigned WB    = FW / 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [RV-1:0]       flush_pc;
    logic                fetch_valid;
    logic                fetch_ready;
    logic [FW-1:0]       fetch_data;
    logic [RV-1:0]       fetch_pc;
    logic [1:0]          out_count;
    logic [NOUT*16-1:0]  out_ins;
    logic [RV-1:0]       out_pc;
    logic [1:0]          consume;

    ins_queue #(.RV(RV), .FW(FW), .DEPTH(DEPTH), .NOUT(NOUT)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .flush_i      (flush),
        .flush_pc_i   (flush_pc),
        .fetch_valid_i(fetch_valid),
        .fetch_ready_o(fetch_ready),
        .fetch_data_i (fetch_data),
        .fetch_pc_i   (fetch_pc),
        .out_count_o  (out_count),
        .out_ins_o    (out_ins),
        .out_pc_o     (out_pc),
        .consume_i    (consume)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]         cnt;
        logic [NOUT*16-1:0] ins;
        logic [RV-1:0]      pc;
        logic               rdy;
    } exp_t;

    exp_t          exp_q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    bit            done   = 0;

    // Reference model: a plain queue of parcels plus redirect bookkeeping.
    logic [15:0]   mq[$];
    logic [RV-1:0] m_out_pc;
    logic [RV-1:0] m_exp_pc;
    int            m_skip;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_out_pc = '0;
        m_exp_pc = '0;
        m_skip   = 0;
    endfunction

    function automatic bit m_ready();
        int sz;
        sz = mq.size();
        return (int'(DEPTH) - sz) >= int'(P);
    endfunction

    function automatic void push_expect();
        exp_t e;
        int   sz;
        sz    = mq.size();
        e.cnt = 2'((sz < int'(NOUT)) ? sz : int'(NOUT));
        e.ins = '0;
        for (int k = 0; k < int'(NOUT); k++) begin
            if (k < sz) e.ins[16*k +: 16] = mq[k];
        end
        e.pc  = m_out_pc;
        e.rdy = m_ready();
        exp_q.push_back(e);
    endfunction

    function automatic void model_step(input bit fl, input logic [RV-1:0] ft, input bit fv,
                                       input logic [FW-1:0] fd, input logic [RV-1:0] fp,
                                       input int cons);
        bit rdy;
        rdy = m_ready();
        if (fl) begin
            mq.delete();
            m_out_pc = ft - (ft % 2);
            m_exp_pc = ft - (ft % WB);
            m_skip   = int'((ft % WB) / 2);
        end else begin
            for (int i = 0; i < cons; i++) void'(mq.pop_front());
            m_out_pc = m_out_pc + RV'(2 * cons);
            if (fv && rdy && fp == m_exp_pc) begin
                for (int i = m_skip; i < int'(P); i++) mq.push_back(fd[16*i +: 16]);
                m_skip   = 0;
                m_exp_pc = m_exp_pc + RV'(WB);
            end
        end
    endfunction

    // Apply one cycle of stimulus; returns #1 after the edge with outputs settled.
    task automatic drive(input bit fl, input logic [RV-1:0] ft, input bit fv,
                         input logic [FW-1:0] fd, input logic [RV-1:0] fp, input int cons);
        flush       = fl;
        flush_pc    = ft;
        fetch_valid = fv;
        fetch_data  = fd;
        fetch_pc    = fp;
        consume     = 2'(cons);
        model_step(fl, ft, fv, fd, fp, cons);
        @(posedge clk);
        #1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        consume     = 2'd0;
        push_expect();
    endtask

    task automatic idle_word(input logic [FW-1:0] fd, input logic [RV-1:0] fp);
        drive(1'b0, '0, 1'b1, fd, fp, 0);
    endtask

    // Reset is asserted mid-cycle, so this cycle's expectation becomes the reset state.
    task automatic do_reset();
        void'(exp_q.pop_back());
        model_reset();
        push_expect();
        rst = 1'b1;
        #1;
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        @(posedge clk);
        #1;
        push_expect();
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per cycle and compares the live outputs.
    initial begin
        exp_t               e;
        logic [NOUT*16-1:0] mask;
        forever begin
            @(negedge clk);
            assert (consume <= out_count) else $error("consume %0d exceeds out_count %0d", consume, out_count);
            if (!done && exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                mask = '0;
                for (int k = 0; k < int'(NOUT); k++) begin
                    if (k < int'(e.cnt)) mask[16*k +: 16] = 16'hFFFF;
                end
                check("out_count", 64'(out_count), 64'(e.cnt));
                check("out_pc", 64'(out_pc), 64'(e.pc));
                check("fetch_ready", 64'(fetch_ready), 64'(e.rdy));
                check("out_ins", 64'(out_ins & mask), 64'(e.ins & mask));
            end
        end
    end

    initial begin
        int            sz;
        int            maxc;
        int            cons;
        bit            fl;
        bit            fv;
        logic [RV-1:0] ft;
        logic [RV-1:0] fp;

        rst         = 1'b1;
        flush       = 1'b0;
        flush_pc    = '0;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        fetch_pc    = '0;
        consume     = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push_expect();
        rst = 1'b0;

        // Aligned fill and consume
        drive(1'b1, 32'h100, 1'b0, '0, '0, 0);
        idle_word(32'hBBBBAAAA, 32'h100);
        check("fill_count", 64'(out_count), 64'd2);
        check("fill_ins", 64'(out_ins), 64'hBBBBAAAA);
        check("fill_pc", 64'(out_pc), 64'h100);
        drive(1'b0, '0, 1'b0, '0, '0, 2);
        check("drain_count", 64'(out_count), 64'd0);
        check("drain_pc", 64'(out_pc), 64'h104);

        // Odd (halfword) redirect drops the low parcel
        drive(1'b1, 32'h202, 1'b0, '0, '0, 0);
        idle_word(32'h22221111, 32'h200);
        check("odd_count", 64'(out_count), 64'd1);
        check("odd_ins0", 64'(out_ins[15:0]), 64'h2222);
        check("odd_pc", 64'(out_pc), 64'h202);
        idle_word(32'h44443333, 32'h204);
        check("odd_next_count", 64'(out_count), 64'd2);
        check("odd_next_ins", 64'(out_ins), 64'h33332222);

        // Stale word is handshaken and dropped
        drive(1'b1, 32'h300, 1'b0, '0, '0, 0);
        idle_word(32'h12345678, 32'h104);
        check("stale_count", 64'(out_count), 64'd0);
        idle_word(32'h66665555, 32'h300);
        check("stale_then_match", 64'(out_count), 64'd2);

        // Full and wrap
        drive(1'b1, 32'h400, 1'b0, '0, '0, 0);
        idle_word(32'hD0B1D0A1, 32'h400);
        idle_word(32'hD1B1D1A1, 32'h404);
        idle_word(32'hD2B1D2A1, 32'h408);
        idle_word(32'hD3B1D3A1, 32'h40C);
        check("full_ready", 64'(fetch_ready), 64'd0);
        drive(1'b0, '0, 1'b1, 32'hD4B1D4A1, 32'h410, 2);
        check("after_consume_ready", 64'(fetch_ready), 64'd1);
        drive(1'b0, '0, 1'b1, 32'hD4B1D4A1, 32'h410, 2);
        drive(1'b0, '0, 1'b0, '0, '0, 2);
        drive(1'b0, '0, 1'b0, '0, '0, 2);
        check("wrap_count", 64'(out_count), 64'd2);
        check("wrap_ins", 64'(out_ins), 64'hD4B1D4A1);
        check("wrap_pc", 64'(out_pc), 64'h410);

        // Flush, consume and fetch in the same cycle
        drive(1'b1, 32'h500, 1'b1, 32'hEEEEEEEE, 32'h414, 2);
        check("simul_count", 64'(out_count), 64'd0);
        check("simul_pc", 64'(out_pc), 64'h500);

        // Reset mid-fill with six parcels queued
        drive(1'b1, 32'h600, 1'b0, '0, '0, 0);
        idle_word(32'h0A0A0B0B, 32'h600);
        idle_word(32'h0C0C0D0D, 32'h604);
        idle_word(32'h0E0E0F0F, 32'h608);
        do_reset();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            sz   = mq.size();
            maxc = (sz < int'(NOUT)) ? sz : int'(NOUT);
            cons = int'($urandom_range(maxc, 0));
            fl   = ($urandom_range(99, 0) < 4);
            ft   = RV'($urandom_range(4095, 0));
            fv   = ($urandom_range(99, 0) < 75);
            if ($urandom_range(99, 0) < 80) fp = m_exp_pc;
            else fp = m_exp_pc + RV'(WB * $urandom_range(3, 1));
            drive(fl, ft, fv, FW'($urandom()), fp, cons);
        end

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
